eth10_tx_scheduler: RTL

- Sequences the 10BASE-T Manchester transmitter running on the 20 MHz system clock.
- Arbitrates frame requests from two frame sources using round-robin.
- Enforces the 9.6 us inter-packet gap and runs a watchdog on each frame.
- Issues Normal Link Pulses (NLPs) when the line is idle and drives the TX activity LED.

---
 rtl/eth10_tx_scheduler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/eth10_tx_scheduler.sv
// eth10_tx_scheduler: frame and link-pulse sequencer for a 10BASE-T Manchester
// transmitter on a 20 MHz clock. Two-source round-robin arbitration, inter-packet
// gap, per-frame watchdog, idle Normal Link Pulses and a stretched TX LED.
// Every output is driven straight from a register.
module eth10_tx_scheduler #(
   parameter int unsigned IPG_CYCLES       = 192,
   parameter int unsigned NLP_PERIOD       = 320000,
   parameter int unsigned NLP_WIDTH        = 2,
   parameter int unsigned MAX_FRAME_CYCLES = 25000,
   parameter int unsigned LED_HOLD         = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] grant,
   output logic       tx_start,
   output logic       tx_sel,
   input  logic       tx_done,
   output logic       tx_nlp,
   output logic       busy,
   output logic       led_tx,
   output logic       err_timeout
);

   localparam int unsigned IPG_W = $clog2(IPG_CYCLES + 1);
   localparam int unsigned NLP_W = $clog2(NLP_PERIOD + 1);
   localparam int unsigned NPW_W = $clog2(NLP_WIDTH + 1);
   localparam int unsigned WD_W  = $clog2(MAX_FRAME_CYCLES + 1);
   localparam int unsigned LED_W = $clog2(LED_HOLD + 1);

   localparam logic [IPG_W-1:0] IPG_LAST = IPG_W'(IPG_CYCLES - 1);
   localparam logic [NLP_W-1:0] NLP_LAST = NLP_W'(NLP_PERIOD - 1);
   localparam logic [NPW_W-1:0] NPW_LAST = NPW_W'(NLP_WIDTH - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(MAX_FRAME_CYCLES - 1);
   localparam logic [LED_W-1:0] LED_LOAD = LED_W'(LED_HOLD);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BUSY,
      S_IPG,
      S_NLP
   } state_t;

   state_t           state_q;
   logic [1:0]       grant_q;
   logic             tx_start_q;
   logic             tx_sel_q;
   logic             tx_nlp_q;
   logic             busy_q;
   logic             led_q;
   logic             err_q;
   logic             last_grant_q;
   logic [IPG_W-1:0] ipg_cnt_q;
   logic [NLP_W-1:0] nlp_cnt_q;
   logic [NPW_W-1:0] npw_cnt_q;
   logic [WD_W-1:0]  wd_cnt_q;
   logic [LED_W-1:0] led_cnt_q;

   logic             winner_d;
   logic [LED_W-1:0] led_cnt_d;

   // Round-robin winner for the current request pattern and LED stretch countdown
   always_comb begin
      winner_d = 1'b0;
      if (req == 2'b11) begin
         winner_d = ~last_grant_q;
      end else if (req == 2'b10) begin
         winner_d = 1'b1;
      end
      led_cnt_d = led_cnt_q;
      if (led_cnt_q != '0) begin
         led_cnt_d = led_cnt_q - LED_W'(1);
      end
   end

   // Scheduler FSM with all counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         tx_start_q   <= 1'b0;
         tx_sel_q     <= 1'b0;
         tx_nlp_q     <= 1'b0;
         busy_q       <= 1'b0;
         led_q        <= 1'b0;
         err_q        <= 1'b0;
         last_grant_q <= 1'b1;
         ipg_cnt_q    <= '0;
         nlp_cnt_q    <= '0;
         npw_cnt_q    <= '0;
         wd_cnt_q     <= '0;
         led_cnt_q    <= '0;
      end else begin
         grant_q    <= '0;
         tx_start_q <= 1'b0;
         err_q      <= 1'b0;
         led_cnt_q  <= led_cnt_d;
         led_q      <= (led_cnt_d != '0);

         unique case (state_q)
            S_IDLE: begin
               if (en && (nlp_cnt_q != NLP_LAST)) begin
                  nlp_cnt_q <= nlp_cnt_q + NLP_W'(1);
               end
               // A pending frame request takes priority over a due link pulse
               if (en && (req != 2'b00)) begin
                  state_q      <= S_START;
                  tx_start_q   <= 1'b1;
                  grant_q      <= winner_d ? 2'b10 : 2'b01;
                  tx_sel_q     <= winner_d;
                  last_grant_q <= winner_d;
                  busy_q       <= 1'b1;
                  led_q        <= 1'b1;
                  nlp_cnt_q    <= '0;
               end else if (en && (nlp_cnt_q == NLP_LAST)) begin
                  state_q   <= S_NLP;
                  tx_nlp_q  <= 1'b1;
                  busy_q    <= 1'b1;
                  npw_cnt_q <= '0;
               end
            end

            S_START: begin
               state_q  <= S_BUSY;
               wd_cnt_q <= '0;
               led_q    <= 1'b1;
            end

            S_BUSY: begin
               led_q <= 1'b1;
               // tx_done wins over a watchdog expiry in the same cycle
               if (tx_done) begin
                  state_q   <= S_IPG;
                  ipg_cnt_q <= '0;
                  led_cnt_q <= LED_LOAD;
                  led_q     <= (LED_LOAD != '0);
               end else if (wd_cnt_q == WD_LAST) begin
                  state_q   <= S_IPG;
                  err_q     <= 1'b1;
                  ipg_cnt_q <= '0;
                  led_cnt_q <= LED_LOAD;
                  led_q     <= (LED_LOAD != '0);
               end else begin
                  wd_cnt_q <= wd_cnt_q + WD_W'(1);
               end
            end

            S_IPG: begin
               if (en && (nlp_cnt_q != NLP_LAST)) begin
                  nlp_cnt_q <= nlp_cnt_q + NLP_W'(1);
               end
               if (ipg_cnt_q == IPG_LAST) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  ipg_cnt_q <= ipg_cnt_q + IPG_W'(1);
               end
            end

            S_NLP: begin
               if (npw_cnt_q == NPW_LAST) begin
                  state_q   <= S_IDLE;
                  tx_nlp_q  <= 1'b0;
                  busy_q    <= 1'b0;
                  nlp_cnt_q <= '0;
               end else begin
                  npw_cnt_q <= npw_cnt_q + NPW_W'(1);
               end
            end

            default: begin
               state_q  <= S_IDLE;
               tx_nlp_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign grant       = grant_q;
   assign tx_start    = tx_start_q;
   assign tx_sel      = tx_sel_q;
   assign tx_nlp      = tx_nlp_q;
   assign busy        = busy_q;
   assign led_tx      = led_q;
   assign err_timeout = err_q;

endmodule
